// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Serialises CPU and DMA accesses to one unified memory with a
//            fixed MEM_LAT-cycle access time. Define MEM_ARB_RR_EN for
//            round-robin arbitration instead of CPU priority + DMA_WAIT.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int DMA_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ready,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_owner
);

  localparam logic [3:0] c_LAT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_lat_cnt;
  logic                r_owner;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dma_rdata;
  logic                r_cpu_ready;
  logic                r_dma_ready;

  logic                w_grant;
  logic                w_grant_dma;

  assign w_grant = i_cpu_req | i_dma_req;

`ifdef MEM_ARB_RR_EN
  // On contention the port that did not own the last grant wins.
  assign w_grant_dma = i_dma_req & (~i_cpu_req | ~r_owner);
`else
  localparam int STREAK_W = (DMA_WAIT < 1) ? 1 : $clog2(DMA_WAIT + 1);

  logic [STREAK_W-1:0] r_streak;
  logic                w_streak_full;

  assign w_streak_full = (r_streak == STREAK_W'(DMA_WAIT));
  assign w_grant_dma   = i_dma_req & (~i_cpu_req | w_streak_full);

  // Counts CPU grants made over a pending DMA request; only IDLE samples count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!i_dma_req || w_grant_dma) begin
        r_streak <= '0;
      end else if (i_cpu_req && !w_streak_full) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lat_cnt   <= '0;
      r_owner     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_owner   <= w_grant_dma;
            r_mem_en  <= 1'b1;
            r_mem_we  <= w_grant_dma ? i_dma_we    : i_cpu_we;
            r_addr    <= w_grant_dma ? i_dma_addr  : i_cpu_addr;
            r_wdata   <= w_grant_dma ? i_dma_wdata : i_cpu_wdata;
            r_lat_cnt <= c_LAT_INIT;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_lat_cnt == 4'd0) begin
            // Read data is only valid in the last access cycle.
            if (!r_mem_we) begin
              if (r_owner) begin
                r_dma_rdata <= i_mem_rdata;
              end else begin
                r_cpu_rdata <= i_mem_rdata;
              end
            end
            r_cpu_ready <= ~r_owner;
            r_dma_ready <= r_owner;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_dma_rdata = r_dma_rdata;
  assign o_dma_ready = r_dma_ready;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_owner     = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LAT      = 2;
  localparam int DMA_WAIT = 4;
  localparam logic [31:0] K_MEM = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          cpu_ready, dma_ready, mem_en, mem_we, owner;

  logic          b_cpu_req;
  logic [AW-1:0] b_cpu_addr, b_mem_addr;
  logic [DW-1:0] b_cpu_rdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_cpu_ready, b_dma_ready, b_mem_en, b_mem_we, b_owner;

  assign b_mem_rdata = b_mem_addr ^ K_MEM;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .DMA_WAIT(DMA_WAIT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ready(cpu_ready),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata), .o_dma_ready(dma_ready),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .DMA_WAIT(DMA_WAIT)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(b_cpu_req), .i_cpu_we(1'b0), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata('0),
    .o_cpu_rdata(b_cpu_rdata), .o_cpu_ready(b_cpu_ready),
    .i_dma_req(1'b0), .i_dma_we(1'b0), .i_dma_addr('0), .i_dma_wdata('0),
    .o_dma_rdata(b_dma_rdata), .o_dma_ready(b_dma_ready),
    .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .i_mem_rdata(b_mem_rdata), .o_owner(b_owner)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a transaction occupies MEM_LAT access cycles then one
  // response cycle; m_left counts the cycles of it still to come.
  int            m_left;
  int            m_streak;
  logic          m_own, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_dma_rd;
  bit            fixed_rd;

  task automatic model_reset();
    m_left = 0; m_streak = 0; m_own = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dma_rd = '0;
  endtask

  task automatic model_edge();
    int g;
    if (m_left == 0) begin
      g = -1;
`ifdef MEM_ARB_RR_EN
      if (cpu_req && dma_req) g = m_own ? 0 : 1;
      else if (cpu_req)       g = 0;
      else if (dma_req)       g = 1;
`else
      if (cpu_req && dma_req) g = (m_streak == DMA_WAIT) ? 1 : 0;
      else if (cpu_req)       g = 0;
      else if (dma_req)       g = 1;
      if (!dma_req || g == 1) m_streak = 0;
      else if (g == 0 && m_streak < DMA_WAIT) m_streak = m_streak + 1;
`endif
      if (g >= 0) begin
        m_own   = (g == 1);
        m_we    = m_own ? dma_we    : cpu_we;
        m_addr  = m_own ? dma_addr  : cpu_addr;
        m_wdata = m_own ? dma_wdata : cpu_wdata;
        m_left  = LAT + 1;
      end
    end else begin
      if (m_left == 2 && !m_we) begin
        if (m_own) m_dma_rd = mem_rdata;
        else       m_cpu_rd = mem_rdata;
      end
      m_left = m_left - 1;
    end
  endtask

  task automatic check_outputs();
    logic e_en;
    e_en = (m_left >= 2);
    chk("mem_en",    32'(mem_en),    32'(e_en));
    chk("mem_we",    32'(mem_we),    32'(e_en && m_we));
    chk("mem_addr",  mem_addr,       m_addr);
    chk("mem_wdata", mem_wdata,      m_wdata);
    chk("cpu_ready", 32'(cpu_ready), 32'(m_left == 1 && !m_own));
    chk("dma_ready", 32'(dma_ready), 32'(m_left == 1 && m_own));
    chk("cpu_rdata", cpu_rdata,      m_cpu_rd);
    chk("dma_rdata", dma_rdata,      m_dma_rd);
    chk("owner",     32'(owner),     32'(m_own));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    if (!fixed_rd) mem_rdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, en_cnt, last_rdy, rdy_n;
    logic [AW-1:0] granted;
    logic exp_dma;

    rst_n = 1'b0; fixed_rd = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0; b_cpu_req = 0; b_cpu_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk) rst_n = 1'b1;

    // Reset asserted mid-access aborts it with no ready pulse.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h77;
    step();
    chk("t1_en_before_reset", 32'(mem_en), 32'd1);
    cpu_req = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_en_in_reset", 32'(mem_en), 32'd0);
    chk("t1_we_in_reset", 32'(mem_we), 32'd0);
    check_outputs();
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin step(); cnt += int'(cpu_ready | dma_ready); end
    chk("t1_no_ready_after_reset", 32'(cnt), 32'd0);

    // CPU read: mem_en in cycles 1-2, ready in cycle 3.
    fixed_rd = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    step();
    chk("t2_c1_en", 32'(mem_en), 32'd1);
    step();
    chk("t2_c2_en", 32'(mem_en), 32'd1);
    chk("t2_c2_rdy", 32'(cpu_ready), 32'd0);
    step();
    chk("t2_c3_rdy", 32'(cpu_ready), 32'd1);
    chk("t2_c3_en", 32'(mem_en), 32'd0);
    chk("t2_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 0; fixed_rd = 1'b0;

    // DMA write.
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h1234;
    n = 0;
    do begin step(); n++; end while (!mem_en && n < 10);
    chk("t3_started", 32'(mem_en), 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("t3_we", 32'(mem_we), 32'd1);
      chk("t3_addr", mem_addr, 32'h40);
      chk("t3_wdata", mem_wdata, 32'h1234);
      step();
    end
    chk("t3_dma_ready", 32'(dma_ready), 32'd1);
    chk("t3_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("t3_cpu_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    dma_req = 0;

    // Both requesters held high.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h200;
    dma_req = 1; dma_we = 0; dma_addr = 32'h300;
    for (int g = 0; g < 10; g++) begin
      n = 0;
      do begin step(); n++; end while (!(cpu_ready || dma_ready) && n < 12);
      chk("t4_ready_seen", 32'(cpu_ready | dma_ready), 32'd1);
`ifdef MEM_ARB_RR_EN
      exp_dma = (g % 2 == 1);
`else
      exp_dma = (g % 5 == 4);
`endif
      chk("t4_grant_is_dma", 32'(dma_ready), 32'(exp_dma));
    end
    cpu_req = 0; dma_req = 0;

    // Request dropped during the access still completes once.
    n = 0;
    while (m_left != 0 && n < 10) begin step(); n++; end
    step();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h500; cpu_wdata = 32'hCAFE;
    step();
    en_cnt = int'(mem_en);
    cpu_req = 0;
    cnt = 0;
    repeat (8) begin step(); cnt += int'(cpu_ready); en_cnt += int'(mem_en); end
    chk("t5_one_ready", 32'(cnt), 32'd1);
    chk("t5_en_cycles", 32'(en_cnt), 32'(LAT));

    // Randomized traffic against the model.
    repeat (400) begin
      cpu_req = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = $urandom; cpu_wdata = $urandom;
      dma_req = 1'($urandom); dma_we = 1'($urandom);
      dma_addr = $urandom; dma_wdata = $urandom;
      step();
    end
    cpu_req = 0; dma_req = 0;

    // MEM_LAT=1 back-to-back CPU read stream.
    b_cpu_req = 1; b_cpu_addr = $urandom;
    last_rdy = -1; rdy_n = 0; granted = '0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (b_mem_en) begin
        chk("t6_addr_latched", b_mem_addr, b_cpu_addr);
        granted = b_cpu_addr;
      end
      if (b_cpu_ready) begin
        chk("t6_rdata", b_cpu_rdata, granted ^ K_MEM);
        if (last_rdy >= 0) chk("t6_ready_gap", 32'(c - last_rdy), 32'd3);
        last_rdy = c;
        rdy_n++;
      end
      b_cpu_addr = $urandom;
    end
    chk("t6_ready_count", 32'(rdy_n >= 4), 32'd1);
    b_cpu_req = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
